// File: rtl/switch_debounce.sv
// Switch input conditioner: per-channel 2-flop synchroniser followed by a
// debounce counter that accepts a new level only after it has held for
// DEBOUNCE_CYCLES consecutive synchronised cycles.
// Optional feature macro: SWITCH_DEBOUNCE_EDGE_EN builds the registered
// sw_rise/sw_fall pulse outputs; when undefined they are tied to 0.
module switch_debounce #(
  parameter int unsigned N_SW            = 2,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_clean,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall
);

  // Count value on which a persisting mismatch is accepted.
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic [N_SW-1:0]  sync1_q;
  logic [N_SW-1:0]  sync2_q;
  logic [N_SW-1:0]  clean_q;
  logic [N_SW-1:0]  clean_d;
  logic [N_SW-1:0]  mismatch;
  logic [N_SW-1:0]  accept;
  logic [CNT_W-1:0] cnt_q [N_SW];
  logic [CNT_W-1:0] cnt_d [N_SW];

  // Two-flop synchroniser; everything downstream looks at sync2_q only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
    end
  end

  // Next-state: any return to the accepted level discards the count.
  always_comb begin
    mismatch = '0;
    accept   = '0;
    clean_d  = clean_q;
    for (int i = 0; i < int'(N_SW); i++) begin
      cnt_d[i]    = '0;
      mismatch[i] = sync2_q[i] ^ clean_q[i];
      accept[i]   = mismatch[i] && (cnt_q[i] == CntLast);
      if (accept[i]) begin
        clean_d[i] = sync2_q[i];
      end else if (mismatch[i]) begin
        cnt_d[i] = cnt_q[i] + CntOne;
      end
    end
  end

  // Per-channel counters and accepted levels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clean_q <= '0;
      for (int i = 0; i < int'(N_SW); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      clean_q <= clean_d;
      for (int i = 0; i < int'(N_SW); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sw_clean = clean_q;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  logic [N_SW-1:0] rise_q;
  logic [N_SW-1:0] fall_q;

  // Edge pulses registered on the accept edge, so they line up with the
  // first cycle in which sw_clean shows the new level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= accept & sync2_q;
      fall_q <= accept & ~sync2_q;
    end
  end

  assign sw_rise = rise_q;
  assign sw_fall = fall_q;
`else
  assign sw_rise = '0;
  assign sw_fall = '0;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce with DEBOUNCE_CYCLES=4, N_SW=2.
// Per-cycle vector table {rst, sw_raw, expected outputs}; expected values are
// queued when a vector is driven and popped when outputs are sampled.
module tb_switch_debounce;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  localparam bit EdgeEn = 1'b1;
`else
  localparam bit EdgeEn = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [1:0] sw_raw;
  logic [1:0] sw_clean;
  logic [1:0] sw_rise;
  logic [1:0] sw_fall;

  switch_debounce #(
    .N_SW            (2),
    .CNT_W           (16),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw_raw   (sw_raw),
    .sw_clean (sw_clean),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] raw;
    logic [5:0] exp;  // {clean, rise, fall}
    string      tag;
  } vec_t;

  vec_t       vecs[$];
  logic [5:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         split;

  function automatic void hold(input logic r, input logic [1:0] raw, input logic [1:0] clean,
                               input logic [1:0] rise, input logic [1:0] fall, input int n,
                               input string tag);
    vec_t v;
    v.rst = r;
    v.raw = raw;
    v.exp = {clean, rise & {2{EdgeEn}}, fall & {2{EdgeEn}}};
    v.tag = tag;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got clean=%b rise=%b fall=%b, want clean=%b rise=%b fall=%b",
               tag, $time, got[5:4], got[3:2], got[1:0], exp[5:4], exp[3:2], exp[1:0]);
    end
  endtask

  task automatic apply(input vec_t v);
    logic [5:0] e;
    @(negedge clk);
    rst    = v.rst;
    sw_raw = v.raw;
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(v.tag, {sw_clean, sw_rise, sw_fall}, e);
  endtask

  initial begin
    rst    = 1'b0;
    sw_raw = 2'b11;

    // Reset held, then released with raw=11: accept on edge 6.
    hold(0, 2'b11, 2'b00, 2'b00, 2'b00, 3, "rst_hold");
    hold(1, 2'b11, 2'b00, 2'b00, 2'b00, 5, "rst_rel_wait");
    hold(1, 2'b11, 2'b11, 2'b11, 2'b00, 1, "rst_rel_accept");
    hold(1, 2'b11, 2'b11, 2'b00, 2'b00, 2, "rst_rel_after");
    // Drop bit 0 only: fall on edge 6, bit 1 untouched.
    hold(1, 2'b10, 2'b11, 2'b00, 2'b00, 5, "fall_wait");
    hold(1, 2'b10, 2'b10, 2'b00, 2'b01, 1, "fall_accept");
    hold(1, 2'b10, 2'b10, 2'b00, 2'b00, 2, "fall_after");
    // 3-cycle glitch on bit 0 is rejected.
    hold(1, 2'b11, 2'b10, 2'b00, 2'b00, 3, "glitch3_hi");
    hold(1, 2'b10, 2'b10, 2'b00, 2'b00, 6, "glitch3_lo");
    // 4-cycle pulse is accepted, then the return to 0 is accepted too.
    hold(1, 2'b11, 2'b10, 2'b00, 2'b00, 4, "pulse4_hi");
    hold(1, 2'b10, 2'b10, 2'b00, 2'b00, 1, "pulse4_wait");
    hold(1, 2'b10, 2'b11, 2'b01, 2'b00, 1, "pulse4_rise");
    hold(1, 2'b10, 2'b11, 2'b00, 2'b00, 3, "pulse4_hold");
    hold(1, 2'b10, 2'b10, 2'b00, 2'b01, 1, "pulse4_fall");
    hold(1, 2'b10, 2'b10, 2'b00, 2'b00, 2, "pulse4_after");
    // Bring bit 1 low ahead of the bounce test.
    hold(1, 2'b00, 2'b10, 2'b00, 2'b00, 5, "b1_low_wait");
    hold(1, 2'b00, 2'b00, 2'b00, 2'b10, 1, "b1_low_fall");
    hold(1, 2'b00, 2'b00, 2'b00, 2'b00, 2, "b1_low_after");
    // Bounce 1,0,1,0,1 then hold 1: only the final rising run is counted.
    hold(1, 2'b10, 2'b00, 2'b00, 2'b00, 1, "bounce");
    hold(1, 2'b00, 2'b00, 2'b00, 2'b00, 1, "bounce");
    hold(1, 2'b10, 2'b00, 2'b00, 2'b00, 1, "bounce");
    hold(1, 2'b00, 2'b00, 2'b00, 2'b00, 1, "bounce");
    hold(1, 2'b10, 2'b00, 2'b00, 2'b00, 1, "bounce");
    hold(1, 2'b10, 2'b00, 2'b00, 2'b00, 4, "bounce_wait");
    hold(1, 2'b10, 2'b10, 2'b10, 2'b00, 1, "bounce_rise");
    hold(1, 2'b10, 2'b10, 2'b00, 2'b00, 2, "bounce_after");
    // Start 0->1 on bit 0 and stop once its count has reached 2.
    hold(1, 2'b11, 2'b10, 2'b00, 2'b00, 4, "midcnt_run");
    split = vecs.size();
    // After asynchronous reset: full latency again.
    hold(0, 2'b11, 2'b00, 2'b00, 2'b00, 2, "midcnt_rst_hold");
    hold(1, 2'b11, 2'b00, 2'b00, 2'b00, 5, "midcnt_rel_wait");
    hold(1, 2'b11, 2'b11, 2'b11, 2'b00, 1, "midcnt_rel_accept");
    hold(1, 2'b11, 2'b11, 2'b00, 2'b00, 2, "midcnt_rel_after");

    for (int i = 0; i < split; i++) apply(vecs[i]);

    // Asynchronous clear between clock edges.
    check("midcnt_pre_rst", {sw_clean, sw_rise, sw_fall}, 6'b10_00_00);
    #1 rst = 1'b0;
    #1 check("async_rst", {sw_clean, sw_rise, sw_fall}, 6'b00_00_00);

    for (int i = split; i < vecs.size(); i++) apply(vecs[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
